// File: rtl/pe_mac_psum_if.sv
// pe_mac_psum_if
//   Bundles the operand-beat handshake and the partial-sum result handshake
//   of the PE MAC/psum stage.
//   master : operand producer / psum consumer side (drives beats and psum_ready)
//   slave  : the MAC/psum stage itself
// Signals
//   in_valid, in_ready              operand beat handshake
//   ifmap_data, filter_data         signed operands
//   first, last                     convolution window delimiters
//   psum_out, psum_ovf              finished partial sum and its overflow flag
//   psum_valid, psum_ready          result handshake
interface pe_mac_psum_if #(
    parameter int IFMAP_DATA_WIDTH  = 8,
    parameter int FILTER_DATA_WIDTH = 8,
    parameter int PSUM_WIDTH        = 20
);
    logic                                in_valid;
    logic                                in_ready;
    logic signed [IFMAP_DATA_WIDTH-1:0]  ifmap_data;
    logic signed [FILTER_DATA_WIDTH-1:0] filter_data;
    logic                                first;
    logic                                last;
    logic signed [PSUM_WIDTH-1:0]        psum_out;
    logic                                psum_ovf;
    logic                                psum_valid;
    logic                                psum_ready;

    modport master (
        output in_valid, ifmap_data, filter_data, first, last, psum_ready,
        input  in_ready, psum_out, psum_ovf, psum_valid
    );

    modport slave (
        input  in_valid, ifmap_data, filter_data, first, last, psum_ready,
        output in_ready, psum_out, psum_ovf, psum_valid
    );
endinterface

// File: rtl/pe_mac_psum.sv
// pe_mac_psum
//   Downstream MAC/psum stage of the PE. Takes one ifmap/filter operand pair
//   per beat, multiplies (stage 1), accumulates over a first..last window
//   (stage 2) and presents the finished partial sum on a valid/ready output.
//   One beat per cycle; only a closing beat waiting on a full output register
//   back-pressures the input.
// Ports
//   clk   clock, all state updates on posedge
//   rst   synchronous active-high reset
//   bus   pe_mac_psum_if.slave: operand beat in, partial sum out
//   busy  any pipeline stage or the accumulator holds uncommitted data
// Configuration
//   PSUM_SAT_EN  defined: accumulator saturates on overflow
//                undefined: accumulator wraps modulo 2^PSUM_WIDTH
//   psum_ovf reports the overflow in both builds.
module pe_mac_psum #(
    parameter int IFMAP_DATA_WIDTH  = 8,
    parameter int FILTER_DATA_WIDTH = 8,
    parameter int PSUM_WIDTH        = 20
) (
    input  logic              clk,
    input  logic              rst,
    pe_mac_psum_if.slave      bus,
    output logic              busy
);
    localparam int PROD_W = IFMAP_DATA_WIDTH + FILTER_DATA_WIDTH;

    // Signed add with overflow detect; returns {overflow, sum}.
    function automatic logic [PSUM_WIDTH:0] acc_add(
        input logic signed [PSUM_WIDTH-1:0] a,
        input logic signed [PSUM_WIDTH-1:0] b
    );
        logic signed [PSUM_WIDTH-1:0] s;
        logic                         o;
        s = a + b;
        o = (a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1]) && (s[PSUM_WIDTH-1] != a[PSUM_WIDTH-1]);
`ifdef PSUM_SAT_EN
        // Both addends share a sign on overflow, so it picks the clamp rail.
        if (o) begin
            if (a[PSUM_WIDTH-1]) begin
                s = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
            end else begin
                s = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
            end
        end
`endif
        return {o, s};
    endfunction

    logic signed [IFMAP_DATA_WIDTH-1:0]  ifm;
    logic signed [FILTER_DATA_WIDTH-1:0] flt;
    logic signed [PROD_W-1:0]            prod_d;

    logic signed [PROD_W-1:0]     prod_p1;
    logic                         first_p1;
    logic                         last_p1;
    logic                         vld_p1;

    logic signed [PSUM_WIDTH-1:0] acc_p2;
    logic                         acc_ovf_p2;
    logic                         open_p2;
    logic signed [PSUM_WIDTH-1:0] psum_p2;
    logic                         psum_ovf_p2;
    logic                         vld_p2;

    logic signed [PSUM_WIDTH-1:0] prod_ext;
    logic signed [PSUM_WIDTH-1:0] acc_base;
    logic signed [PSUM_WIDTH-1:0] acc_sum;
    logic                         beat_ovf;
    logic                         win_ovf;
    logic                         stall;

    // Only a closing beat needs the output register; it waits while that is full.
    assign stall        = vld_p2 && !bus.psum_ready && vld_p1 && last_p1;
    assign bus.in_ready = !stall;

    assign ifm    = bus.ifmap_data;
    assign flt    = bus.filter_data;
    assign prod_d = PROD_W'(ifm) * PROD_W'(flt);

    // ---- stage 1: multiply ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            prod_p1  <= '0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                prod_p1  <= prod_d;
                first_p1 <= bus.first;
                last_p1  <= bus.last;
            end
        end
    end

    assign prod_ext = PSUM_WIDTH'(prod_p1);
    // A first beat drops whatever partial sum and flag were pending.
    assign acc_base = first_p1 ? '0 : acc_p2;
    assign {beat_ovf, acc_sum} = acc_add(acc_base, prod_ext);
    assign win_ovf  = (first_p1 ? 1'b0 : acc_ovf_p2) | beat_ovf;

    // ---- stage 2: accumulate / output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p2      <= '0;
            acc_ovf_p2  <= 1'b0;
            open_p2     <= 1'b0;
            psum_p2     <= '0;
            psum_ovf_p2 <= 1'b0;
            vld_p2      <= 1'b0;
        end else begin
            if (vld_p1 && !stall) begin
                if (last_p1) begin
                    psum_p2     <= acc_sum;
                    psum_ovf_p2 <= win_ovf;
                    acc_p2      <= '0;
                    acc_ovf_p2  <= 1'b0;
                    open_p2     <= 1'b0;
                end else begin
                    acc_p2      <= acc_sum;
                    acc_ovf_p2  <= win_ovf;
                    open_p2     <= 1'b1;
                end
            end
            // A new result loading on the handshake edge keeps valid high.
            if (vld_p1 && last_p1 && !stall) begin
                vld_p2 <= 1'b1;
            end else if (bus.psum_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    assign bus.psum_out   = psum_p2;
    assign bus.psum_ovf   = psum_ovf_p2;
    assign bus.psum_valid = vld_p2;
    assign busy           = vld_p1 || vld_p2 || open_p2;
endmodule
